// File: rtl/cpu_types_pkg.sv
// Shared CPU types: bus word, RAM status and the memory-arbiter FSM states.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IACC   = 3'd1,
    DACC   = 3'd2,
    IRETRY = 3'd3,
    DRETRY = 3'd4
  } arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and RAM-side signals of the memory arbiter.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  ramstate_t ramstate;
  word_t     ramload;
  logic      iwait;
  logic      dwait;
  word_t     iload;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data has priority, a streak counter bounds how long
// a pending instruction fetch can be passed over.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int DSTREAK_MAX = 4
) (
  input  logic         CLK,
  input  logic         nRST,
  mem_arbiter_if.arb   bus
);
  localparam int            SW    = $clog2(DSTREAK_MAX + 1);
  localparam logic [SW-1:0] L_MAX = SW'(DSTREAK_MAX);

  arb_state_t    r_state;
  logic [SW-1:0] r_dstreak;

  logic w_dreq, w_acc, w_err, w_idone, w_ddone;

  assign w_dreq  = bus.dREN | bus.dWEN;
  assign w_acc   = (bus.ramstate == ACCESS);
  assign w_err   = (bus.ramstate == ERROR);
  // A dropped request never completes, even if the RAM reports ACCESS.
  assign w_idone = (r_state == IACC) && bus.iREN && w_acc;
  assign w_ddone = (r_state == DACC) && w_dreq   && w_acc;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_dstreak <= '0;
    end else begin
      if (!bus.iREN || w_idone)
        r_dstreak <= '0;
      else if (w_ddone && (r_dstreak != L_MAX))
        r_dstreak <= r_dstreak + SW'(1);

      case (r_state)
        IDLE: begin
          if (w_dreq && (r_dstreak < L_MAX)) r_state <= DACC;
          else if (bus.iREN)                 r_state <= IACC;
          else if (w_dreq)                   r_state <= DACC;
        end
        IACC: begin
          if (!bus.iREN || w_acc) r_state <= IDLE;
          else if (w_err)         r_state <= IRETRY;
        end
        DACC: begin
          if (!w_dreq || w_acc) r_state <= IDLE;
          else if (w_err)       r_state <= DRETRY;
        end
        IRETRY:  r_state <= bus.iREN ? IACC : IDLE;
        DRETRY:  r_state <= w_dreq   ? DACC : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (r_state)
      IACC: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
      end
      DACC: begin
        bus.ramREN   = bus.dREN;
        bus.ramWEN   = bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
      end
      default: ;
    endcase
  end

  assign bus.iwait = ~w_idone;
  assign bus.dwait = ~w_ddone;
  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized requesters, checked every cycle against
// an ownership/streak reference model of the arbitration rules.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int DMAX = 4;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  mem_arbiter_if bus ();

  mem_arbiter #(.DSTREAK_MAX(DMAX)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // model: owner 0=none 1=fetch 2=data, pause = one-cycle backoff after ERROR
  int m_own   = 0;
  bit m_pause = 0;
  int m_strk  = 0;
  bit e_iw, e_dw;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic look();
    bit    on, acc;
    logic  e_ren, e_wen;
    word_t e_addr, e_store;
    @(negedge CLK);
    on      = (m_own != 0) && !m_pause;
    acc     = (bus.ramstate == ACCESS);
    e_ren   = on && (m_own == 1 || bus.dREN);
    e_wen   = on && m_own == 2 && bus.dWEN;
    e_addr  = !on ? 32'h0 : (m_own == 1 ? bus.iaddr : bus.daddr);
    e_store = (on && m_own == 2) ? bus.dstore : 32'h0;
    e_iw    = !(on && m_own == 1 && bus.iREN && acc);
    e_dw    = !(on && m_own == 2 && (bus.dREN || bus.dWEN) && acc);
    chk("iwait",    bus.iwait,    e_iw);
    chk("dwait",    bus.dwait,    e_dw);
    chk("ramREN",   bus.ramREN,   e_ren);
    chk("ramWEN",   bus.ramWEN,   e_wen);
    chk("ramaddr",  bus.ramaddr,  e_addr);
    chk("ramstore", bus.ramstore, e_store);
    if (!e_iw) chk("iload", bus.iload, bus.ramload);
    if (!e_dw) chk("dload", bus.dload, bus.ramload);
  endtask

  task automatic tick();
    bit dq, acc, err, ic, dc, rq;
    int ns;
    @(posedge CLK);
    dq  = bus.dREN || bus.dWEN;
    acc = (bus.ramstate == ACCESS);
    err = (bus.ramstate == ERROR);
    ic  = m_own == 1 && !m_pause && bus.iREN && acc;
    dc  = m_own == 2 && !m_pause && dq && acc;
    ns  = (!bus.iREN || ic) ? 0 : (dc ? ((m_strk < DMAX) ? m_strk + 1 : DMAX) : m_strk);
    if (!nRST) begin
      m_own = 0; m_pause = 0; ns = 0;
    end else if (m_own == 0) begin
      if (dq && m_strk < DMAX) m_own = 2;
      else if (bus.iREN)       m_own = 1;
      else if (dq)             m_own = 2;
    end else begin
      rq = (m_own == 1) ? bus.iREN : dq;
      if (!rq)          begin m_own = 0; m_pause = 0; end
      else if (m_pause) m_pause = 0;
      else if (acc)     m_own = 0;
      else if (err)     m_pause = 1;
    end
    m_strk = ns;
    #1;
  endtask

  int seq[$];
  int r;

  initial begin
    nRST = 1'b0;
    bus.iREN = 1'b1; bus.iaddr = '0; bus.dREN = 1'b1; bus.dWEN = 1'b0;
    bus.daddr = '0; bus.dstore = '0; bus.ramstate = FREE; bus.ramload = '0;
    tick(); tick();
    look();
    chk("rst_iwait", bus.iwait, 1'b1);
    chk("rst_dwait", bus.dwait, 1'b1);
    chk("rst_ren",   bus.ramREN, 1'b0);
    tick();

    // lone fetch, zero-wait RAM
    nRST = 1'b1; bus.dREN = 1'b0; bus.iaddr = 32'h40;
    bus.ramstate = ACCESS; bus.ramload = 32'hCAFE_0040;
    look(); tick();
    look();
    chk("lf_ren",   bus.ramREN,  1'b1);
    chk("lf_addr",  bus.ramaddr, 32'h40);
    chk("lf_iwait", bus.iwait,   1'b0);
    chk("lf_iload", bus.iload,   32'hCAFE_0040);
    tick();
    look();
    chk("lf_iwait2", bus.iwait, 1'b1);
    tick();
    bus.iREN = 1'b0;
    look(); tick();

    // simultaneous arrival: write served first
    bus.iREN = 1'b1; bus.iaddr = 32'h80;
    bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD_BEEF;
    look(); tick();
    look();
    chk("pr_wen",   bus.ramWEN,   1'b1);
    chk("pr_addr",  bus.ramaddr,  32'h100);
    chk("pr_store", bus.ramstore, 32'hDEAD_BEEF);
    chk("pr_dwait", bus.dwait,    1'b0);
    chk("pr_iwait", bus.iwait,    1'b1);
    tick();
    bus.dWEN = 1'b0;
    look(); tick();
    look();
    chk("pr_iwait2", bus.iwait, 1'b0);
    tick();
    bus.iREN = 1'b0;
    look(); tick();

    // starvation bound: continuous fetch and data requests
    bus.iREN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h204;
    for (int k = 0; k < 14; k++) begin
      look();
      if (!bus.dwait) seq.push_back(2);
      if (!bus.iwait) seq.push_back(1);
      tick();
    end
    chk("sv_npulse", (seq.size() >= 6), 1'b1);
    if (seq.size() >= 6) begin
      for (int k = 0; k < 4; k++) chk("sv_data", seq[k], 2);
      chk("sv_fetch",  seq[4], 1);
      chk("sv_resume", seq[5], 2);
    end
    bus.iREN = 1'b0; bus.dREN = 1'b0;
    look(); tick();

    // one ERROR during a data read
    bus.dREN = 1'b1; bus.daddr = 32'h200; bus.ramstate = ERROR;
    look(); tick();
    look();
    chk("er_ren1",  bus.ramREN, 1'b1);
    chk("er_dwait", bus.dwait,  1'b1);
    tick();
    bus.ramstate = ACCESS;
    look();
    chk("er_gap", bus.ramREN, 1'b0);
    tick();
    look();
    chk("er_ren2",   bus.ramREN, 1'b1);
    chk("er_dwait2", bus.dwait,  1'b0);
    tick();
    bus.dREN = 1'b0;

    // data request dropped while BUSY, pending fetch then granted
    bus.dREN = 1'b1; bus.daddr = 32'h300; bus.iREN = 1'b1; bus.iaddr = 32'h44;
    bus.ramstate = BUSY;
    look(); tick();
    look();
    chk("dr_ren", bus.ramREN, 1'b1);
    tick();
    bus.dREN = 1'b0;
    look();
    chk("dr_dwait", bus.dwait, 1'b1);
    tick();
    look();
    chk("dr_idle", bus.ramREN, 1'b0);
    tick();
    look();
    chk("dr_iren",  bus.ramREN,  1'b1);
    chk("dr_iaddr", bus.ramaddr, 32'h44);
    tick();

    // reset while the fetch is in flight
    nRST = 1'b0;
    look(); tick();
    look();
    chk("rm_ren",   bus.ramREN, 1'b0);
    chk("rm_iwait", bus.iwait,  1'b1);
    nRST = 1'b1; bus.iREN = 1'b0;
    tick();

    // randomized requesters and RAM
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 9);
      bus.ramstate = (r < 5) ? ACCESS : (r < 8) ? BUSY : (r == 8) ? ERROR : FREE;
      bus.ramload  = $urandom;
      look();
      tick();
      nRST = ($urandom_range(0, 199) != 0);
      if (bus.iREN && (!e_iw || $urandom_range(0, 19) == 0)) bus.iREN = 1'b0;
      else if (!bus.iREN && $urandom_range(0, 2) == 0) begin
        bus.iREN = 1'b1; bus.iaddr = $urandom;
      end
      if ((bus.dREN || bus.dWEN) && (!e_dw || $urandom_range(0, 19) == 0)) begin
        bus.dREN = 1'b0; bus.dWEN = 1'b0;
      end else if (!(bus.dREN || bus.dWEN) && $urandom_range(0, 2) == 0) begin
        bus.dWEN = $urandom_range(0, 1);
        bus.dREN = ~bus.dWEN;
        bus.daddr = $urandom; bus.dstore = $urandom;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
